hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline hazard controller for the RV32 core, companion to the EX->ID operand bypass.
//  Detects load-use hazards the bypass cannot cover, and stalls fetch/decode with an EX bubble.
//  Sequences multi-cycle data-memory accesses and flushes wrong-path instructions after a taken jump/branch.
//  Sits beside the ID/EX pipeline registers and drives their hold/flush/bubble controls.
// PARAMETERS
//  FLUSH_CYCLES  2    cycles IF/ID is flushed after a taken jump (>=1; covers fetch latency)
//  MEM_TIMEOUT   255  max wait cycles for MEM_ack before abort (1..255, 8-bit counter)
// PORTS
//  clk           in   1   core clock, rising edge
//  rst           in   1   asynchronous reset, active-high
//  ID_rs1        in   5   rs1 address of instruction in ID
//  ID_rs2        in   5   rs2 address of instruction in ID
//  ID_rs1_used   in   1   ID instruction reads rs1
//  ID_rs2_used   in   1   ID instruction reads rs2
//  EX_rd         in   5   destination register of instruction in EX
//  EX_is_load    in   1   EX instruction is a load (result not yet available for bypass)
//  EX_jump       in   1   EX resolved a taken branch/JAL/JALR this cycle
//  MEM_req       in   1   EX/MEM issues a data-memory access this cycle
//  MEM_ack       in   1   data memory completes the outstanding access
//  HC_pc_hold    out  1   freeze PC
//  HC_ifid_hold  out  1   freeze IF/ID register
//  HC_ifid_flush out  1   clear IF/ID to NOP
//  HC_idex_bubble out 1   load NOP into ID/EX
//  HC_exmem_hold out  1   freeze EX/MEM register
//  HC_mem_err    out  1   one-cycle pulse: memory access timed out
//  HC_state      out  2   FSM state (debug)
// BEHAVIOUR
//  - Reset: state=RUN, flush_cnt=0, wait_cnt=0, all outputs 0; reset mid-wait/flush abandons the operation.
//  - Outputs are combinational from the registered state and current inputs; state updates on the rising clk edge.
//  - States: RUN(0), MEM_WAIT(1), FLUSH(2); value 3 is unused and recovers to RUN.
//  - lu_haz = EX_is_load & EX_rd!=0 & ((ID_rs1_used & ID_rs1==EX_rd) | (ID_rs2_used & ID_rs2==EX_rd)).
//  - RUN priority, highest first:
//    1) MEM_req & !MEM_ack: pc_hold, ifid_hold, exmem_hold, and idex_bubble=0 (whole pipe frozen);
//       ->MEM_WAIT, wait_cnt=1.
//    2) EX_jump: ifid_flush=1, idex_bubble=1; FLUSH_CYCLES>1 ->FLUSH with flush_cnt=FLUSH_CYCLES-1,
//       otherwise stay in RUN.
//    3) lu_haz: pc_hold=1, ifid_hold=1, idex_bubble=1 for exactly one cycle; stay in RUN.
//    - MEM_req & MEM_ack in the same cycle is zero-wait: no stall, and jump/lu_haz are evaluated.
//  - MEM_WAIT: pc_hold, ifid_hold, and exmem_hold are 1.
//    - MEM_ack -> RUN; holds drop in that same cycle.
//    - Otherwise wait_cnt++. When wait_cnt==MEM_TIMEOUT and there is no ack: HC_mem_err=1 for 1 cycle, ->RUN.
//    - MEM_ack on the timeout cycle wins: no error.
//    - EX_jump and lu_haz are ignored in MEM_WAIT; the EX inputs are frozen and are re-evaluated in RUN.
//  - FLUSH: ifid_flush=1, other outputs 0; flush_cnt--; ->RUN when flush_cnt reaches 0.
//    - A new EX_jump in FLUSH reloads flush_cnt=FLUSH_CYCLES-1.
//    - MEM_req in FLUSH is ignored (a flushed pipe issues none).
//  - rd==x0 never creates a hazard.
//  - The bypass covers non-load EX results, so no stall is raised for them.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined: adds output HC_stall_cnt[31:0].
//    - Increments each cycle pc_hold==1; wraps 0xFFFFFFFF->0; reset to 0.
//  Not defined: port and counter are absent; all other behaviour is identical.
// TESTING
//  1) lw x5 in EX (EX_is_load=1, EX_rd=5); ID add reads x5 via rs2
//     -> pc_hold, ifid_hold, and idex_bubble are 1 for 1 cycle, then 0.
//  2) EX_rd=0 load with ID_rs1=0 -> no stall.
//     Non-load EX_rd=5 with ID_rs1=5 -> no stall.
//  3) MEM_req=1, MEM_ack arrives 3 cycles later
//     -> holds high 3 cycles (state=1), drop in the ack cycle, state=0.
//  4) MEM_TIMEOUT=4, MEM_req with no ack -> HC_mem_err pulses on the 4th wait cycle, state back to 0.
//  5) FLUSH_CYCLES=2, EX_jump -> ifid_flush=1 for 2 cycles with idex_bubble only in the first;
//     EX_jump together with lu_haz -> the jump wins, no pc_hold.
//  6) Assert rst during MEM_WAIT -> all outputs 0 immediately.
//     With HAZARD_PERF_CNT_EN: after test 3, HC_stall_cnt==3.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, multi-cycle memory waits, wrong-path flushes.
// Define HAZARD_PERF_CNT_EN to add the HC_stall_cnt performance counter output.
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] ID_rs1,
  input  logic [4:0] ID_rs2,
  input  logic       ID_rs1_used,
  input  logic       ID_rs2_used,
  input  logic [4:0] EX_rd,
  input  logic       EX_is_load,
  input  logic       EX_jump,
  input  logic       MEM_req,
  input  logic       MEM_ack,
  output logic       HC_pc_hold,
  output logic       HC_ifid_hold,
  output logic       HC_ifid_flush,
  output logic       HC_idex_bubble,
  output logic       HC_exmem_hold,
  output logic       HC_mem_err,
  output logic [1:0] HC_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] HC_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam logic [7:0] FLUSH_LOAD  = 8'(FLUSH_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_VAL = 8'(MEM_TIMEOUT);

  state_t     state, state_n;
  logic [7:0] wait_cnt, wait_cnt_n;
  logic [7:0] flush_cnt, flush_cnt_n;
  logic       lu_haz;

  // Loads are the only EX results the bypass cannot forward in time.
  assign lu_haz = EX_is_load && (EX_rd != 5'd0) &&
                  ((ID_rs1_used && (ID_rs1 == EX_rd)) ||
                   (ID_rs2_used && (ID_rs2 == EX_rd)));

  assign HC_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= 8'd0;
      flush_cnt <= 8'd0;
    end else begin
      state     <= state_n;
      wait_cnt  <= wait_cnt_n;
      flush_cnt <= flush_cnt_n;
    end
  end

  always_comb begin
    state_n        = state;
    wait_cnt_n     = wait_cnt;
    flush_cnt_n    = flush_cnt;
    HC_pc_hold     = 1'b0;
    HC_ifid_hold   = 1'b0;
    HC_ifid_flush  = 1'b0;
    HC_idex_bubble = 1'b0;
    HC_exmem_hold  = 1'b0;
    HC_mem_err     = 1'b0;

    case (state)
      RUN: begin
        if (MEM_req && !MEM_ack) begin
          HC_pc_hold    = 1'b1;
          HC_ifid_hold  = 1'b1;
          HC_exmem_hold = 1'b1;
          state_n       = MEM_WAIT;
          wait_cnt_n    = 8'd1;
        end else if (EX_jump) begin
          HC_ifid_flush  = 1'b1;
          HC_idex_bubble = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_n     = FLUSH;
            flush_cnt_n = FLUSH_LOAD;
          end
        end else if (lu_haz) begin
          HC_pc_hold     = 1'b1;
          HC_ifid_hold   = 1'b1;
          HC_idex_bubble = 1'b1;
        end
      end

      // EX inputs are frozen here, so jumps and load-use are deliberately ignored.
      MEM_WAIT: begin
        if (MEM_ack) begin
          state_n    = RUN;
          wait_cnt_n = 8'd0;
        end else begin
          HC_pc_hold    = 1'b1;
          HC_ifid_hold  = 1'b1;
          HC_exmem_hold = 1'b1;
          if (wait_cnt >= TIMEOUT_VAL) begin
            HC_mem_err = 1'b1;
            state_n    = RUN;
            wait_cnt_n = 8'd0;
          end else begin
            wait_cnt_n = wait_cnt + 8'd1;
          end
        end
      end

      FLUSH: begin
        HC_ifid_flush = 1'b1;
        if (EX_jump) begin
          flush_cnt_n = FLUSH_LOAD;
        end else if (flush_cnt <= 8'd1) begin
          state_n     = RUN;
          flush_cnt_n = 8'd0;
        end else begin
          flush_cnt_n = flush_cnt - 8'd1;
        end
      end

      default: begin
        state_n     = RUN;
        wait_cnt_n  = 8'd0;
        flush_cnt_n = 8'd0;
      end
    endcase
  end

`ifdef HAZARD_PERF_CNT_EN
  // Counts every cycle the PC is frozen, for any reason.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      HC_stall_cnt <= 32'd0;
    end else if (HC_pc_hold) begin
      HC_stall_cnt <= HC_stall_cnt + 32'd1;
    end
  end
`else
  // Performance counter not built in this configuration.
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard testbench for hazard_ctrl (FLUSH_CYCLES=2, MEM_TIMEOUT=4).
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] ID_rs1, ID_rs2, EX_rd;
  logic       ID_rs1_used, ID_rs2_used, EX_is_load, EX_jump, MEM_req, MEM_ack;
  logic       HC_pc_hold, HC_ifid_hold, HC_ifid_flush, HC_idex_bubble;
  logic       HC_exmem_hold, HC_mem_err;
  logic [1:0] HC_state;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] HC_stall_cnt;
  int          exp_stall = 0;
`endif

  hazard_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_rs1_used(ID_rs1_used), .ID_rs2_used(ID_rs2_used),
    .EX_rd(EX_rd), .EX_is_load(EX_is_load), .EX_jump(EX_jump),
    .MEM_req(MEM_req), .MEM_ack(MEM_ack),
    .HC_pc_hold(HC_pc_hold), .HC_ifid_hold(HC_ifid_hold), .HC_ifid_flush(HC_ifid_flush),
    .HC_idex_bubble(HC_idex_bubble), .HC_exmem_hold(HC_exmem_hold),
    .HC_mem_err(HC_mem_err), .HC_state(HC_state)
`ifdef HAZARD_PERF_CNT_EN
    , .HC_stall_cnt(HC_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       pc, ifid_h, flush, bubble, exmem, err;
    logic [1:0] st;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs are compared mid-cycle, against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput({e.name, ".pc_hold"},   32'(HC_pc_hold),     32'(e.pc));
      checkOutput({e.name, ".ifid_hold"}, 32'(HC_ifid_hold),   32'(e.ifid_h));
      checkOutput({e.name, ".flush"},     32'(HC_ifid_flush),  32'(e.flush));
      checkOutput({e.name, ".bubble"},    32'(HC_idex_bubble), 32'(e.bubble));
      checkOutput({e.name, ".exmem"},     32'(HC_exmem_hold),  32'(e.exmem));
      checkOutput({e.name, ".mem_err"},   32'(HC_mem_err),     32'(e.err));
      checkOutput({e.name, ".state"},     32'(HC_state),       32'(e.st));
    end
  end

  // Called just after a rising edge; drives one cycle and queues its expected outputs.
  task automatic applyStimulus(input string name,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic [4:0] rd,
                               input logic ld, input logic jmp, input logic req, input logic ack,
                               input logic epc, input logic eih, input logic efl,
                               input logic ebu, input logic eex, input logic eer,
                               input logic [1:0] est);
    exp_t e;
    ID_rs1 = rs1; ID_rs2 = rs2; ID_rs1_used = u1; ID_rs2_used = u2;
    EX_rd = rd; EX_is_load = ld; EX_jump = jmp; MEM_req = req; MEM_ack = ack;
    e.name = name; e.pc = epc; e.ifid_h = eih; e.flush = efl;
    e.bubble = ebu; e.exmem = eex; e.err = eer; e.st = est;
    sb.push_back(e);
`ifdef HAZARD_PERF_CNT_EN
    if (epc) exp_stall++;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, ".pc_hold"},   32'(HC_pc_hold),     32'd0);
    checkOutput({name, ".ifid_hold"}, 32'(HC_ifid_hold),   32'd0);
    checkOutput({name, ".flush"},     32'(HC_ifid_flush),  32'd0);
    checkOutput({name, ".bubble"},    32'(HC_idex_bubble), 32'd0);
    checkOutput({name, ".exmem"},     32'(HC_exmem_hold),  32'd0);
    checkOutput({name, ".mem_err"},   32'(HC_mem_err),     32'd0);
    checkOutput({name, ".state"},     32'(HC_state),       32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    ID_rs1 = 5'd0; ID_rs2 = 5'd0; ID_rs1_used = 1'b0; ID_rs2_used = 1'b0;
    EX_rd = 5'd0; EX_is_load = 1'b0; EX_jump = 1'b0; MEM_req = 1'b0; MEM_ack = 1'b0;
    #2;
    checkAllZero("reset");
`ifdef HAZARD_PERF_CNT_EN
    checkOutput("reset.stall_cnt", HC_stall_cnt, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Load-use detection and its qualifiers
    applyStimulus("lu_rs2",    5'd3, 5'd5, 1, 1, 5'd5, 1, 0, 0, 0,  1, 1, 0, 1, 0, 0, 2'd0);
    applyStimulus("lu_after",  5'd3, 5'd5, 1, 1, 5'd0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 2'd0);
    applyStimulus("lu_rs1",    5'd7, 5'd2, 1, 1, 5'd7, 1, 0, 0, 0,  1, 1, 0, 1, 0, 0, 2'd0);
    applyStimulus("lu_unused", 5'd7, 5'd2, 0, 1, 5'd7, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 2'd0);
    applyStimulus("x0_load",   5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 2'd0);
    applyStimulus("nonload",   5'd5, 5'd1, 1, 1, 5'd5, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 2'd0);
    applyStimulus("zero_wait", 5'd5, 5'd0, 1, 0, 5'd5, 1, 0, 1, 1,  1, 1, 0, 1, 0, 0, 2'd0);

    // Memory wait with ack three cycles after the request
    applyStimulus("mw_req",    5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0,  1, 1, 0, 0, 1, 0, 2'd0);
    applyStimulus("mw_w1",     5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0,  1, 1, 0, 0, 1, 0, 2'd1);
    applyStimulus("mw_w2_jmp", 5'd5, 5'd0, 1, 0, 5'd5, 1, 1, 0, 0,  1, 1, 0, 0, 1, 0, 2'd1);
    applyStimulus("mw_ack",    5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 2'd1);
    applyStimulus("mw_run",    5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 2'd0);
`ifdef HAZARD_PERF_CNT_EN
    checkOutput("mw.stall_cnt", HC_stall_cnt, 32'(exp_stall));
`endif

    // Timeout, then ack arriving exactly on the timeout cycle
    applyStimulus("to_req",    5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0,  1, 1, 0, 0, 1, 0, 2'd0);
    for (int i = 1; i <= 3; i++)
      applyStimulus($sformatf("to_w%0d", i), 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0,
                    1, 1, 0, 0, 1, 0, 2'd1);
    applyStimulus("to_w4",     5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0,  1, 1, 0, 0, 1, 1, 2'd1);
    applyStimulus("to_run",    5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 2'd0);
    applyStimulus("ta_req",    5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0,  1, 1, 0, 0, 1, 0, 2'd0);
    for (int i = 1; i <= 3; i++)
      applyStimulus($sformatf("ta_w%0d", i), 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0,
                    1, 1, 0, 0, 1, 0, 2'd1);
    applyStimulus("ta_w4_ack", 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 2'd1);
    applyStimulus("ta_run",    5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 2'd0);

    // Jump flush, jump beating load-use, reload and ignored MEM_req in FLUSH
    applyStimulus("jmp",       5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0,  0, 0, 1, 1, 0, 0, 2'd0);
    applyStimulus("jmp_f1",    5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 2'd2);
    applyStimulus("jmp_run",   5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 2'd0);
    applyStimulus("jlu",       5'd0, 5'd5, 0, 1, 5'd5, 1, 1, 0, 0,  0, 0, 1, 1, 0, 0, 2'd0);
    applyStimulus("jlu_f1",    5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0, 2'd2);
    applyStimulus("jlu_run",   5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 2'd0);
    applyStimulus("rl_jmp",    5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0,  0, 0, 1, 1, 0, 0, 2'd0);
    applyStimulus("rl_jmp2",   5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 0,  0, 0, 1, 0, 0, 0, 2'd2);
    applyStimulus("rl_req",    5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0,  0, 0, 1, 0, 0, 0, 2'd2);
    applyStimulus("rl_run",    5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 2'd0);

    // Asynchronous reset in the middle of a memory wait
    applyStimulus("rw_req",    5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0,  1, 1, 0, 0, 1, 0, 2'd0);
    applyStimulus("rw_w1",     5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0,  1, 1, 0, 0, 1, 0, 2'd1);
    rst = 1'b1;
    #1;
    checkAllZero("rst_wait");
`ifdef HAZARD_PERF_CNT_EN
    checkOutput("rst_wait.stall_cnt", HC_stall_cnt, 32'd0);
    exp_stall = 0;
`endif
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus("post_rst",  5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 2'd0);
    applyStimulus("post_lu",   5'd9, 5'd0, 1, 0, 5'd9, 1, 0, 0, 0,  1, 1, 0, 1, 0, 0, 2'd0);

    @(negedge clk);
    #1;
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
